// File: rtl/usb_bridge_tx_framer.sv
// Response framer: turns one captured read/write response into a byte stream
// SYNC, STAT, [DATA x4], CSUM for the downstream byte FIFO.
module usb_bridge_tx_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        resp_valid_i,
  input  logic        resp_rd_i,
  input  logic [1:0]  resp_status_i,
  input  logic [31:0] resp_data_i,
  output logic        resp_accept_o,
  output logic [7:0]  data_out_o,
  output logic        push_o,
  input  logic        accept_i,
  output logic        busy_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SYNC = 3'd1;
  localparam logic [2:0] STAT = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic        rd_q;
  logic [1:0]  status_q;
  logic [31:0] data_q;
  logic [1:0]  cnt_q;
  logic [7:0]  sum_q;

  logic        in_idle;
  logic        in_sync;
  logic        in_stat;
  logic        in_data;
  logic        in_csum;
  logic        capture;
  logic        xfer;
  logic [7:0]  stat_byte;
  logic [7:0]  data_byte;

  assign in_idle = (state_q == IDLE);
  assign in_sync = (state_q == SYNC);
  assign in_stat = (state_q == STAT);
  assign in_data = (state_q == DATA);
  assign in_csum = (state_q == CSUM);

  assign resp_accept_o = in_idle;
  assign push_o        = ~in_idle;
  assign busy_o        = ~in_idle;

  assign capture   = resp_valid_i & resp_accept_o;
  assign xfer      = push_o & accept_i;
  assign stat_byte = {rd_q, 5'b0, status_q};

  always_comb begin
    data_byte = 8'h00;
    unique case (cnt_q)
      2'd0: data_byte = data_q[7:0];
      2'd1: data_byte = data_q[15:8];
      2'd2: data_byte = data_q[23:16];
      2'd3: data_byte = data_q[31:24];
      default: data_byte = 8'h00;
    endcase
  end

  always_comb begin
    data_out_o = 8'h00;
    unique case (1'b1)
      in_sync: data_out_o = SYNC_BYTE;
      in_stat: data_out_o = stat_byte;
      in_data: data_out_o = data_byte;
      in_csum: data_out_o = sum_q;
      default: data_out_o = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (capture) state_d = SYNC;
      SYNC: if (xfer) state_d = STAT;
      STAT: if (xfer) state_d = rd_q ? DATA : CSUM;
      DATA: if (xfer && cnt_q == 2'd3) state_d = CSUM;
      CSUM: if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The sum is seeded with the STAT byte at capture; SYNC never enters it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_q     <= 1'b0;
      status_q <= 2'b00;
      data_q   <= 32'h0;
      cnt_q    <= 2'd0;
      sum_q    <= 8'h00;
    end else if (capture) begin
      rd_q     <= resp_rd_i;
      status_q <= resp_status_i;
      data_q   <= resp_rd_i ? resp_data_i : 32'h0;
      cnt_q    <= 2'd0;
      sum_q    <= {resp_rd_i, 5'b0, resp_status_i};
    end else if (xfer && in_data) begin
      cnt_q    <= cnt_q + 2'd1;
      sum_q    <= sum_q + data_byte;
    end
  end

endmodule

// File: tb/tb_usb_bridge_tx_framer.sv
// Bench for usb_bridge_tx_framer: fixed vectors, corner sequences and
// random frames compared against a byte-list model of the frame format.
module tb_usb_bridge_tx_framer;

  typedef logic [6:0][7:0] frame_t;

  typedef struct {
    logic        rd;
    logic [1:0]  st;
    logic [31:0] d;
    int          stall;
    int          len;
    frame_t      exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resp_valid = 1'b0;
  logic        resp_rd = 1'b0;
  logic [1:0]  resp_status = 2'b00;
  logic [31:0] resp_data = 32'h0;
  logic        resp_accept;
  logic [7:0]  data_out;
  logic        push;
  logic        accept = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usb_bridge_tx_framer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .resp_valid_i  (resp_valid),
    .resp_rd_i     (resp_rd),
    .resp_status_i (resp_status),
    .resp_data_i   (resp_data),
    .resp_accept_o (resp_accept),
    .data_out_o    (data_out),
    .push_o        (push),
    .accept_i      (accept),
    .busy_o        (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Frame built from the format rules: sync, status, LSB-first data, sum.
  function automatic void model(input logic rd, input logic [1:0] st,
                                input logic [31:0] d, output frame_t f,
                                output int n);
    int s;
    f = '0;
    f[0] = 8'hA5;
    f[1] = {rd, 5'b0, st};
    s = int'(f[1]);
    n = 2;
    if (rd) begin
      for (int i = 0; i < 4; i++) begin
        f[n] = d[8*i +: 8];
        s += int'(d[8*i +: 8]);
        n++;
      end
    end
    f[n] = 8'(s % 256);
    n++;
  endfunction

  // Called at the negedge right after the capture edge.
  task automatic play(input frame_t f, input int n, input int stall,
                      input string nm);
    int idx = 0;
    int cyc = 0;
    logic acc;
    while (idx < n && cyc < 64) begin
      chk({nm, "_push"}, 32'(push), 32'd1);
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_racc"}, 32'(resp_accept), 32'd0);
      chk($sformatf("%s_byte%0d", nm, idx), 32'(data_out), 32'(f[idx]));
      case (stall)
        0: acc = 1'b1;
        1: acc = (cyc % 2) == 1;
        default: acc = 1'($urandom_range(0, 1));
      endcase
      accept = acc;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    if (idx < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d bytes expected %0d", nm, idx, n);
    end
    accept = 1'b0;
    chk({nm, "_end_push"}, 32'(push), 32'd0);
    chk({nm, "_end_busy"}, 32'(busy), 32'd0);
    chk({nm, "_end_racc"}, 32'(resp_accept), 32'd1);
  endtask

  task automatic do_frame(input logic rd, input logic [1:0] st,
                          input logic [31:0] d, input frame_t f,
                          input int n, input int stall, input string nm);
    chk({nm, "_idle_racc"}, 32'(resp_accept), 32'd1);
    resp_valid = 1'b1;
    resp_rd = rd;
    resp_status = st;
    resp_data = d;
    @(negedge clk);
    resp_valid = 1'b0;
    resp_rd = 1'($urandom_range(0, 1));
    resp_status = 2'($urandom);
    resp_data = $urandom;
    play(f, n, stall, nm);
  endtask

  vec_t vecs[6];

  initial begin
    frame_t f;
    frame_t fb;
    int n;
    int nb;
    logic rd;
    logic [1:0] st;
    logic [31:0] d;

    vecs[0] = '{1'b1, 2'd0, 32'h12345678, 0, 7,
      {8'h94, 8'h12, 8'h34, 8'h56, 8'h78, 8'h80, 8'hA5}};
    vecs[1] = '{1'b0, 2'd2, 32'hCAFEF00D, 0, 3,
      {32'h0, 8'h02, 8'h02, 8'hA5}};
    vecs[2] = '{1'b1, 2'd3, 32'hFFFFFFFF, 1, 7,
      {8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h83, 8'hA5}};
    vecs[3] = '{1'b0, 2'd1, 32'hDEADBEEF, 1, 3,
      {32'h0, 8'h01, 8'h01, 8'hA5}};
    vecs[4] = '{1'b1, 2'd1, 32'h00000000, 0, 7,
      {8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'hA5}};
    vecs[5] = '{1'b1, 2'd2, 32'h01020304, 0, 7,
      {8'h8C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h82, 8'hA5}};

    #3;
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_racc", 32'(resp_accept), 32'd1);
    chk("rst_data", 32'(data_out), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      do_frame(vecs[i].rd, vecs[i].st, vecs[i].d, vecs[i].exp,
               vecs[i].len, vecs[i].stall, $sformatf("vec%0d", i));
    end

    // Back-to-back reads with resp_valid held high throughout.
    model(1'b1, 2'd0, 32'hA1B2C3D4, f, n);
    model(1'b1, 2'd1, 32'h0F1E2D3C, fb, nb);
    resp_valid = 1'b1;
    resp_rd = 1'b1;
    resp_status = 2'd0;
    resp_data = 32'hA1B2C3D4;
    @(negedge clk);
    resp_status = 2'd1;
    resp_data = 32'h0F1E2D3C;
    play(f, n, 0, "b2b_first");
    @(negedge clk);
    resp_valid = 1'b0;
    play(fb, nb, 0, "b2b_second");

    // Reset in the middle of the DATA bytes, then a clean write ack.
    resp_valid = 1'b1;
    resp_rd = 1'b1;
    resp_status = 2'd3;
    resp_data = 32'h89ABCDEF;
    @(negedge clk);
    resp_valid = 1'b0;
    accept = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_pre_push", 32'(push), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_push", 32'(push), 32'd0);
    chk("midrst_data", 32'(data_out), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_racc", 32'(resp_accept), 32'd1);
    accept = 1'b0;
    @(negedge clk);
    chk("midrst_hold_push", 32'(push), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_after_push", 32'(push), 32'd0);
    do_frame(1'b0, 2'd1, 32'h0, {32'h0, 8'h01, 8'h01, 8'hA5}, 3, 0,
             "post_rst_ack");

    for (int k = 0; k < 24; k++) begin
      rd = 1'($urandom_range(0, 1));
      st = 2'($urandom);
      d = $urandom;
      model(rd, st, d, f, n);
      do_frame(rd, st, d, f, n, 2, $sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
